lemming_world: RTL and testbench
================================

# lemming_world

Closed-loop 1-D terrain model for the lemming walker FSM: tracks the lemming's column and depth and owns a per-column floor-depth map. From these it drives the FSM's `bump_left`, `bump_right` and `ground` inputs. It consumes the FSM's `walk_left`, `walk_right`, `aaah` and `digging` outputs, so the lemming moves, falls and digs through the map. It sits directly upstream of the FSM in the lemmings top level; the bench drives `dig` straight to the FSM.

## Interface
- `COLS`, 16: number of columns, ≥ 2.
- `DEPTH_MAX`, 31: deepest floor level (bedrock); floors range 0..DEPTH_MAX.
- `DIG_CYCLES`, 4: consecutive grounded digging cycles that lower the current column by one level, ≥ 1.
- `START_X`, 0: column after reset.
- `clk` in 1: clock.
- `areset` in 1: reset, asynchronous, active-high.
- `walk_left`, `walk_right`, `aaah`, `digging` in 1 each: FSM outputs; at most one is high.
- `cfg_we` in 1: floor-map write strobe.
- `cfg_col` in XW: column to write, where XW = clog2(COLS).
- `cfg_depth` in DW: floor depth to write, where DW = clog2(DEPTH_MAX+1).
- `bump_left`, `bump_right`, `ground` out 1 each: to the FSM.
- `x_pos` out XW: current column.
- `y_pos` out DW: current depth; 0 is the top level, larger is deeper.

## Operation
- State registers:
  - `x`, `y`;
  - `floor[0..COLS-1]` (DW bits each);
  - `dig_cnt`, which counts 0..DIG_CYCLES-1.
- Combinational outputs, derived only from registers (no combinational path from inputs):
  - `ground` = (`floor[x]` == `y`).
  - `bump_left` = (`x` == 0) OR (`floor[x-1]` < `y`). A neighbour floor shallower than the lemming's depth acts as a wall.
  - `bump_right` = (`x` == COLS-1) OR (`floor[x+1]` < `y`).
  - Out-of-range neighbour indices are never evaluated; the edge term dominates.
- Per-cycle update, in priority order:
  - Walk left: `walk_left` AND NOT `bump_left` → `x` ← `x`-1.
  - Walk right: `walk_right` AND NOT `bump_right` → `x` ← `x`+1.
  - Blocked walk: if walking against a bump, `x` holds; the FSM turns on its own.
  - Fall: `aaah` AND NOT `ground` → `y` ← `y`+1. `y` never exceeds `floor[x]`, because a fall stops once `y` equals the floor.
  - Dig: `digging` AND `ground` AND `floor[x]` < DEPTH_MAX → `dig_cnt` increments. When `dig_cnt` == DIG_CYCLES-1: `floor[x]` ← `floor[x]`+1 and `dig_cnt` ← 0. `ground` then drops the next cycle and the FSM falls one level.
  - Bedrock: digging at `floor[x]` == DEPTH_MAX leaves the floor unchanged and holds `dig_cnt` at 0. The lemming digs forever, as the FSM requires.
  - Any cycle without `digging` → `dig_cnt` ← 0. An interrupted dig loses its progress.
- Walking into a deeper column (`floor[x±1]` > `y`) leaves `ground` low on the next cycle, so the FSM falls.
- All FSM outputs low (splattered or dead) → `x`, `y` and the map freeze. Only `cfg_we` can change the map.
- `cfg_we` → `floor[cfg_col]` ← `cfg_depth`. It overrides a same-cycle dig increment to the same column; that dig's `dig_cnt` clears. `cfg_col` ≥ COLS is ignored.
- Writing a floor shallower than the current `y` under the lemming is legal: `ground` goes low, but the lemming does not rise. The bench must avoid this, and an assertion flags it.

## Timing
- Reset values:
  - `x` = START_X, `y` = 0, every `floor` = 0, `dig_cnt` = 0.
  - Outputs after reset: `ground` = 1, `x_pos` = START_X, `y_pos` = 0.
  - `bump_left` = (START_X == 0); `bump_right` = (START_X == COLS-1).
  - Reset mid-dig or mid-fall discards all state, including map writes.
- Outputs change only on `clk` edges or on `areset`.
- Closed loop:
  - The FSM samples these outputs on edge N and updates its state.
  - This block samples the FSM outputs (derived from FSM state before edge N) on the same edge.
  - Result: one cycle of loop latency, and no combinational cycle.
- Dig latency: after DIG_CYCLES grounded digging cycles, `ground` is low in the following cycle.
- Fall rate: one level per cycle.
- Fall-length accounting toward the FSM's 20-cycle splat limit is owned by the FSM, not by this block.

## Structure
- Shared package `lemmings_pkg`:
  - default COLS, DEPTH_MAX, DIG_CYCLES;
  - XW and DW derivation functions;
  - the FSM state encoding constants, shared with the walker.
- Sub-module `lemming_floor_map`:
  - holds the `floor` array;
  - one combinational read of `x-1`, `x` and `x+1` (edge-clamped);
  - one write port that arbitrates cfg over dig-increment.
- The top-level `lemming_world` holds `x`, `y`, `dig_cnt` and the output logic.

## Test plan
- Reset, START_X=0, flat map, FSM walking left → `bump_left`=1 every cycle; the FSM turns right; `x_pos` counts 1..15, then `bump_right`=1 at x=15.
- `floor[5]`=3, lemming walking right from x=4 → cycle 1: x=5, `ground`=0; `y_pos` goes 1, 2, 3 on successive cycles; `ground`=1 at y=3; the FSM resumes walking right.
- With y=3 in column 5 and `floor[6]`=0 → `bump_right`=1; `x` holds; the FSM turns left.
- Grounded digging, DIG_CYCLES=4 → `floor[x]` increments after exactly 4 cycles; `ground`=0 the next cycle; `y_pos`+1. Dig for 3 cycles, stop one cycle, dig again → 4 more cycles are needed.
- `floor[x]`=31 while digging → no map change and `ground` stays 1 for 50 cycles. Same-cycle `cfg_we` to the dug column at the completing dig cycle → the cfg value wins.
- Assert `areset` mid-fall at y=7 → `y_pos`=0, `x_pos`=START_X and the map is all zeros immediately, before any `clk` edge.

Source files
------------

// File: rtl/lemmings_pkg.sv
// Shared definitions for the lemmings walker and its terrain model:
// default geometry, index-width helper and the walker state encoding.
package lemmings_pkg;

    localparam int COLS_DEF       = 16;
    localparam int DEPTH_MAX_DEF  = 31;
    localparam int DIG_CYCLES_DEF = 4;

    // Width of an index able to address n distinct values (never below 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Walker FSM state encoding, shared with the walker itself.
    typedef enum logic [2:0] {
        ST_WALK_L = 3'd0,
        ST_WALK_R = 3'd1,
        ST_FALL_L = 3'd2,
        ST_FALL_R = 3'd3,
        ST_DIG_L  = 3'd4,
        ST_DIG_R  = 3'd5,
        ST_SPLAT  = 3'd6
    } lemming_state_e;

endpackage

// File: rtl/lemming_floor_map.sv
// Per-column floor-depth map. One combinational read of the columns left of,
// under and right of the lemming (clamped at the edges) and one write port
// where a configuration write beats a dig increment to the same column.
module lemming_floor_map
    import lemmings_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int XW   = idx_width(COLS_DEF),
    parameter int DW   = idx_width(DEPTH_MAX_DEF + 1)
) (
    input  logic          clk,
    input  logic          areset,
    input  logic [XW-1:0] x,
    input  logic          dig_inc,
    input  logic          cfg_we,
    input  logic [XW-1:0] cfg_col,
    input  logic [DW-1:0] cfg_depth,
    output logic [DW-1:0] floor_left,
    output logic [DW-1:0] floor_here,
    output logic [DW-1:0] floor_right
);

    localparam logic [XW-1:0] LAST_X = XW'(COLS - 1);

    logic [DW-1:0] floor_q [COLS];
    logic [DW-1:0] floor_d [COLS];
    logic [XW-1:0] idx_left_s;
    logic [XW-1:0] idx_right_s;

    // Next map contents: cfg write first, then the dig increment under the lemming.
    // A cfg_col beyond the last column matches no entry and is dropped.
    always_comb begin
        for (int i = 0; i < COLS; i++) begin
            floor_d[i] = floor_q[i];
            if (cfg_we && (cfg_col == XW'(i))) begin
                floor_d[i] = cfg_depth;
            end else if (dig_inc && (x == XW'(i))) begin
                floor_d[i] = floor_q[i] + DW'(1'b1);
            end else begin
                floor_d[i] = floor_q[i];
            end
        end
    end

    // Map storage; reset flattens every column to the top level.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < COLS; i++) begin
                floor_q[i] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < COLS; i++) begin
                floor_q[i] <= floor_d[i];
            end
        end
    end

    // Neighbour indices clamped at the edges; callers mask edge reads themselves.
    always_comb begin
        idx_left_s  = x;
        idx_right_s = x;
        if (x == {XW{1'b0}}) begin
            idx_left_s = x;
        end else begin
            idx_left_s = x - XW'(1'b1);
        end
        if (x == LAST_X) begin
            idx_right_s = x;
        end else begin
            idx_right_s = x + XW'(1'b1);
        end
    end

    assign floor_left  = floor_q[idx_left_s];
    assign floor_here  = floor_q[x];
    assign floor_right = floor_q[idx_right_s];

endmodule

// File: rtl/lemming_world_chk.sv
// Checks on how the terrain model is driven: walker outputs stay one-hot-or-idle
// and no floor is ever written above a lemming standing in that column.
module lemming_world_chk #(
    parameter int XW = 4,
    parameter int DW = 5
) (
    input logic          clk,
    input logic          areset,
    input logic          walk_left,
    input logic          walk_right,
    input logic          aaah,
    input logic          digging,
    input logic          cfg_we,
    input logic [XW-1:0] cfg_col,
    input logic [DW-1:0] cfg_depth,
    input logic [XW-1:0] x_pos,
    input logic [DW-1:0] y_pos
);

    a_fsm_onehot0: assert property (@(posedge clk) disable iff (areset)
        $onehot0({walk_left, walk_right, aaah, digging}))
        else $error("lemming_world_chk: more than one walker output high");

    a_no_raise_under: assert property (@(posedge clk) disable iff (areset)
        !(cfg_we && (cfg_col == x_pos) && (cfg_depth < y_pos)))
        else $error("lemming_world_chk: floor written above the lemming in its column");

endmodule

// File: rtl/lemming_world.sv
// Closed-loop 1-D terrain model for the lemming walker: tracks the lemming's
// column and depth, owns the floor map, and derives bump/ground for the walker
// purely from registered state so the loop has one cycle of latency.
module lemming_world
    import lemmings_pkg::*;
#(
    parameter int COLS       = COLS_DEF,
    parameter int DEPTH_MAX  = DEPTH_MAX_DEF,
    parameter int DIG_CYCLES = DIG_CYCLES_DEF,
    parameter int START_X    = 0,
    parameter int XW         = idx_width(COLS),
    parameter int DW         = idx_width(DEPTH_MAX + 1)
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          walk_left,
    input  logic          walk_right,
    input  logic          aaah,
    input  logic          digging,
    input  logic          cfg_we,
    input  logic [XW-1:0] cfg_col,
    input  logic [DW-1:0] cfg_depth,
    output logic          bump_left,
    output logic          bump_right,
    output logic          ground,
    output logic [XW-1:0] x_pos,
    output logic [DW-1:0] y_pos
);

    localparam int            CW       = idx_width(DIG_CYCLES);
    localparam logic [XW-1:0] LAST_X   = XW'(COLS - 1);
    localparam logic [DW-1:0] DMAX     = DW'(DEPTH_MAX);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIG_CYCLES - 1);

    logic [XW-1:0] x_q, x_d;
    logic [DW-1:0] y_q, y_d;
    logic [CW-1:0] dig_cnt_q, dig_cnt_d;
    logic          dig_inc_s;
    logic [DW-1:0] floor_left_s, floor_here_s, floor_right_s;

    lemming_floor_map #(
        .COLS (COLS),
        .XW   (XW),
        .DW   (DW)
    ) u_map (
        .clk         (clk),
        .areset      (areset),
        .x           (x_q),
        .dig_inc     (dig_inc_s),
        .cfg_we      (cfg_we),
        .cfg_col     (cfg_col),
        .cfg_depth   (cfg_depth),
        .floor_left  (floor_left_s),
        .floor_here  (floor_here_s),
        .floor_right (floor_right_s)
    );

    // A shallower neighbour floor is a wall; the edge term short-circuits the clamped read.
    assign ground     = (floor_here_s == y_q);
    assign bump_left  = (x_q == {XW{1'b0}}) || (floor_left_s < y_q);
    assign bump_right = (x_q == LAST_X) || (floor_right_s < y_q);
    assign x_pos      = x_q;
    assign y_pos      = y_q;

    // Next position and dig progress from the walker's current request.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        dig_cnt_d = {CW{1'b0}};
        dig_inc_s = 1'b0;

        if (walk_left && !bump_left) begin
            x_d = x_q - XW'(1'b1);
        end else if (walk_right && !bump_right) begin
            x_d = x_q + XW'(1'b1);
        end else begin
            x_d = x_q;
        end

        // The depth guard keeps a lemming from sinking below a floor lifted above it.
        if (aaah && !ground && (y_q < floor_here_s)) begin
            y_d = y_q + DW'(1'b1);
        end else begin
            y_d = y_q;
        end

        // At bedrock, or whenever digging stops, progress is discarded.
        if (digging && ground && (floor_here_s < DMAX)) begin
            if (dig_cnt_q == LAST_CNT) begin
                dig_inc_s = 1'b1;
                dig_cnt_d = {CW{1'b0}};
            end else begin
                dig_cnt_d = dig_cnt_q + CW'(1'b1);
            end
        end else begin
            dig_cnt_d = {CW{1'b0}};
        end
    end

    // Lemming position and dig counter registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            x_q       <= XW'(START_X);
            y_q       <= {DW{1'b0}};
            dig_cnt_q <= {CW{1'b0}};
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            dig_cnt_q <= dig_cnt_d;
        end
    end

    lemming_world_chk #(
        .XW (XW),
        .DW (DW)
    ) u_chk (
        .clk        (clk),
        .areset     (areset),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .aaah       (aaah),
        .digging    (digging),
        .cfg_we     (cfg_we),
        .cfg_col    (cfg_col),
        .cfg_depth  (cfg_depth),
        .x_pos      (x_q),
        .y_pos      (y_q)
    );

endmodule

// File: tb/tb_lemming_world.sv
// Bench for lemming_world with default geometry (16 columns, bedrock 31,
// 4-cycle dig, start at column 0). Stimulus rows carry their expected outputs,
// which are queued when driven and compared one edge later.
module tb_lemming_world;

    logic       clk = 1'b0;
    logic       areset;
    logic       walk_left, walk_right, aaah, digging;
    logic       cfg_we;
    logic [3:0] cfg_col;
    logic [4:0] cfg_depth;
    logic       bump_left, bump_right, ground;
    logic [3:0] x_pos;
    logic [4:0] y_pos;

    typedef struct {
        logic [3:0] ex;
        logic [4:0] ey;
        logic       eg;
        logic       ebl;
        logic       ebr;
        string      nm;
    } exp_t;

    typedef struct {
        logic       wl, wr, aa, dg, we;
        logic [3:0] col;
        logic [4:0] dep;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    lemming_world #(
        .COLS       (16),
        .DEPTH_MAX  (31),
        .DIG_CYCLES (4),
        .START_X    (0)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .aaah       (aaah),
        .digging    (digging),
        .cfg_we     (cfg_we),
        .cfg_col    (cfg_col),
        .cfg_depth  (cfg_depth),
        .bump_left  (bump_left),
        .bump_right (bump_right),
        .ground     (ground),
        .x_pos      (x_pos),
        .y_pos      (y_pos)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk_e(input int ex, input int ey, input logic eg,
                                  input logic ebl, input logic ebr, input string nm);
        exp_t e;
        e.ex = 4'(ex); e.ey = 5'(ey); e.eg = eg; e.ebl = ebl; e.ebr = ebr; e.nm = nm;
        return e;
    endfunction

    function automatic vec_t mk_v(input logic wl, input logic wr, input logic aa,
                                  input logic dg, input logic we, input int col,
                                  input int dep, input exp_t e);
        vec_t v;
        v.wl = wl; v.wr = wr; v.aa = aa; v.dg = dg; v.we = we;
        v.col = 4'(col); v.dep = 5'(dep); v.e = e;
        return v;
    endfunction

    task automatic check_out();
        exp_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: output seen with no expectation queued");
        end else begin
            e = sb_q.pop_front();
            if ({x_pos, y_pos, ground, bump_left, bump_right} !==
                {e.ex, e.ey, e.eg, e.ebl, e.ebr}) begin
                n_bad++;
                $display("FAIL %s: got x=%0d y=%0d g=%b bl=%b br=%b, want x=%0d y=%0d g=%b bl=%b br=%b",
                         e.nm, x_pos, y_pos, ground, bump_left, bump_right,
                         e.ex, e.ey, e.eg, e.ebl, e.ebr);
            end
        end
    endtask

    task automatic step(input vec_t v);
        walk_left = v.wl; walk_right = v.wr; aaah = v.aa; digging = v.dg;
        cfg_we = v.we; cfg_col = v.col; cfg_depth = v.dep;
        sb_q.push_back(v.e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Asynchronous reset away from any edge; state must clear before the next edge.
    task automatic do_reset(input string nm);
        walk_left = 1'b0; walk_right = 1'b0; aaah = 1'b0; digging = 1'b0;
        cfg_we = 1'b0; cfg_col = 4'd0; cfg_depth = 5'd0;
        areset = 1'b1;
        #1;
        sb_q.push_back(mk_e(0, 0, 1'b1, 1'b1, 1'b0, nm));
        check_out();
        @(negedge clk);
        areset = 1'b0;
    endtask

    initial begin
        areset = 1'b0;
        walk_left = 1'b0; walk_right = 1'b0; aaah = 1'b0; digging = 1'b0;
        cfg_we = 1'b0; cfg_col = 4'd0; cfg_depth = 5'd0;
        #2;
        do_reset("reset_init");

        // Flat map: left wall at column 0, walk across to the right wall.
        step(mk_v(1, 0, 0, 0, 0, 0, 0, mk_e(0, 0, 1'b1, 1'b1, 1'b0, "walk_left_wall")));
        for (int i = 1; i <= 15; i++) begin
            step(mk_v(0, 1, 0, 0, 0, 0, 0, mk_e(i, 0, 1'b1, 1'b0, (i == 15), "walk_right")));
        end
        step(mk_v(0, 1, 0, 0, 0, 0, 0, mk_e(15, 0, 1'b1, 1'b0, 1'b1, "walk_right_wall")));

        do_reset("reset_2");

        // Pit at column 5, fall into it, walls, interrupted dig, cfg beating a dig.
        tbl.push_back(mk_v(0, 0, 0, 0, 1, 5, 3, mk_e(0, 0, 1'b1, 1'b1, 1'b0, "cfg_pit")));
        for (int i = 1; i <= 4; i++) begin
            tbl.push_back(mk_v(0, 1, 0, 0, 0, 0, 0, mk_e(i, 0, 1'b1, 1'b0, 1'b0, "walk_to_pit")));
        end
        tbl.push_back(mk_v(0, 1, 0, 0, 0, 0, 0, mk_e(5, 0, 1'b0, 1'b0, 1'b0, "enter_pit")));
        tbl.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(5, 1, 1'b0, 1'b1, 1'b1, "fall_1")));
        tbl.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(5, 2, 1'b0, 1'b1, 1'b1, "fall_2")));
        tbl.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(5, 3, 1'b1, 1'b1, 1'b1, "fall_land")));
        tbl.push_back(mk_v(0, 1, 0, 0, 0, 0, 0, mk_e(5, 3, 1'b1, 1'b1, 1'b1, "blocked_right")));
        tbl.push_back(mk_v(1, 0, 0, 0, 0, 0, 0, mk_e(5, 3, 1'b1, 1'b1, 1'b1, "blocked_left")));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk_v(0, 0, 0, 1, 0, 0, 0, mk_e(5, 3, 1'b1, 1'b1, 1'b1, "dig_partial")));
        end
        tbl.push_back(mk_v(0, 0, 0, 0, 0, 0, 0, mk_e(5, 3, 1'b1, 1'b1, 1'b1, "dig_pause")));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk_v(0, 0, 0, 1, 0, 0, 0, mk_e(5, 3, 1'b1, 1'b1, 1'b1, "dig_restart")));
        end
        tbl.push_back(mk_v(0, 0, 0, 1, 0, 0, 0, mk_e(5, 3, 1'b0, 1'b1, 1'b1, "dig_complete")));
        tbl.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(5, 4, 1'b1, 1'b1, 1'b1, "dig_fall")));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk_v(0, 0, 0, 1, 0, 0, 0, mk_e(5, 4, 1'b1, 1'b1, 1'b1, "dig_again")));
        end
        tbl.push_back(mk_v(0, 0, 0, 1, 1, 5, 10, mk_e(5, 4, 1'b0, 1'b1, 1'b1, "cfg_beats_dig")));
        for (int y = 5; y <= 10; y++) begin
            tbl.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(5, y, (y == 10), 1'b1, 1'b1, "fall_to_cfg")));
        end
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Bedrock: dig forever without changing the map.
        do_reset("reset_3");
        step(mk_v(0, 0, 0, 0, 1, 0, 31, mk_e(0, 0, 1'b0, 1'b1, 1'b0, "cfg_bedrock")));
        for (int y = 1; y <= 31; y++) begin
            step(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(0, y, (y == 31), 1'b1, 1'b1, "fall_bedrock")));
        end
        for (int i = 0; i < 50; i++) begin
            step(mk_v(0, 0, 0, 1, 0, 0, 0, mk_e(0, 31, 1'b1, 1'b1, 1'b1, "dig_bedrock")));
        end

        // Reset in the middle of a fall wipes position and map.
        do_reset("reset_4");
        step(mk_v(0, 0, 0, 0, 1, 0, 20, mk_e(0, 0, 1'b0, 1'b1, 1'b0, "cfg_deep")));
        for (int y = 1; y <= 7; y++) begin
            step(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(0, y, 1'b0, 1'b1, 1'b1, "fall_deep")));
        end
        do_reset("reset_midfall");
        step(mk_v(0, 1, 0, 0, 0, 0, 0, mk_e(1, 0, 1'b1, 1'b0, 1'b0, "post_reset_right")));
        step(mk_v(1, 0, 0, 0, 0, 0, 0, mk_e(0, 0, 1'b1, 1'b1, 1'b0, "post_reset_map_clear")));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
